// File: rtl/alu_pkg.sv
// Shared definitions for the execute/writeback slice.
//   - 3-bit branch condition codes (CC_EQ .. CC_AL)
//   - bit positions inside the {S,Z,C,V} flag nibble
//   - encoding of the 2-entry skid buffer occupancy state
//   - cond_holds(): evaluates a condition code against a flag nibble
package alu_pkg;

    localparam logic [2:0] CC_EQ = 3'b000;
    localparam logic [2:0] CC_LT = 3'b001;
    localparam logic [2:0] CC_LE = 3'b010;
    localparam logic [2:0] CC_NE = 3'b011;
    localparam logic [2:0] CC_CS = 3'b100;
    localparam logic [2:0] CC_GE = 3'b101;
    localparam logic [2:0] CC_GT = 3'b110;
    localparam logic [2:0] CC_AL = 3'b111;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    // Signed comparisons use S^V (sign corrected for overflow).
    function automatic logic cond_holds(input logic [3:0] flags, input logic [2:0] cc);
        logic lt;
        logic z;
        lt = flags[FLAG_S] ^ flags[FLAG_V];
        z  = flags[FLAG_Z];
        case (cc)
            CC_EQ:   cond_holds = z;
            CC_LT:   cond_holds = lt;
            CC_LE:   cond_holds = z | lt;
            CC_NE:   cond_holds = ~z;
            CC_CS:   cond_holds = flags[FLAG_C];
            CC_GE:   cond_holds = ~lt;
            CC_GT:   cond_holds = ~z & ~lt;
            default: cond_holds = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry FIFO-ordered valid/ready buffer.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   push                enqueue in_data this cycle (only legal while in_ready)
//   in_ready            registered: buffer is not full
//   in_data [W-1:0]     payload to enqueue
//   out_valid           head entry is valid
//   out_ready           consumer takes the head entry
//   out_data [W-1:0]    head entry payload, held while stalled
module skid_buffer2
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state_reg;
    skid_state_t  state_next;
    logic [W-1:0] head_reg;
    logic [W-1:0] tail_reg;
    logic         ready_reg;
    logic         pop;

    assign pop       = (state_reg != SKID_EMPTY) & out_ready;
    assign out_valid = (state_reg != SKID_EMPTY);
    assign out_data  = head_reg;
    assign in_ready  = ready_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SKID_EMPTY: if (push) state_next = SKID_ONE;
            SKID_ONE: begin
                if (push && !pop)      state_next = SKID_TWO;
                else if (!push && pop) state_next = SKID_EMPTY;
            end
            SKID_TWO:   if (pop) state_next = SKID_ONE;
            default:    state_next = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= SKID_EMPTY;
            ready_reg <= 1'b0;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else begin
            state_reg <= state_next;
            // Ready is a pure register so the upstream never sees a
            // combinational path from out_ready.
            ready_reg <= (state_next != SKID_TWO);
            if (((state_reg == SKID_EMPTY) && push) ||
                ((state_reg == SKID_ONE) && push && pop))
                head_reg <= in_data;
            else if ((state_reg == SKID_TWO) && pop)
                head_reg <= tail_reg;
            if ((state_reg == SKID_ONE) && push && !pop)
                tail_reg <= in_data;
        end
    end

endmodule

// File: rtl/exec_result_stage.sv
// Execute-to-writeback stage behind the ALU. Owns the architectural flag
// register, resolves conditional branches against it, squashes the
// branch-shadow beats after a taken branch and forwards surviving beats
// through a 2-entry skid buffer.
// Ports:
//   CLK, RST_N                 clock, synchronous active-low reset
//   IN_VALID / IN_READY        upstream handshake (IN_READY registered)
//   ALU_OUT, FLAG_OUT, FLAG_WE ALU result, {S,Z,C,V}, flag write enable
//   REG_WE, DEST               register write enable and index
//   BR_EN, BR_COND, BR_TARGET  conditional branch request
//   OUT_VALID / OUT_READY      writeback handshake
//   WB_DATA, WB_DEST, WB_WE    writeback payload
//   BR_TAKEN, BR_PC            one-cycle pulse and target of a taken branch
//   FLAGS                      architectural flag register
module exec_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int SHADOW = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] ALU_OUT,
    input  logic [3:0]        FLAG_OUT,
    input  logic              FLAG_WE,
    input  logic              REG_WE,
    input  logic [REG_AW-1:0] DEST,
    input  logic              BR_EN,
    input  logic [2:0]        BR_COND,
    input  logic [DATA_W-1:0] BR_TARGET,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] WB_DATA,
    output logic [REG_AW-1:0] WB_DEST,
    output logic              WB_WE,
    output logic              BR_TAKEN,
    output logic [DATA_W-1:0] BR_PC,
    output logic [3:0]        FLAGS
);

    localparam int         PW          = 1 + REG_AW + DATA_W;
    localparam logic [1:0] SHADOW_LOAD = 2'(SHADOW);

    logic [3:0]        flags_reg;
    logic [1:0]        shadow_cnt_reg;
    logic              br_taken_reg;
    logic [DATA_W-1:0] br_pc_reg;

    logic              accept;
    logic              squash;
    logic              live;
    logic              taken;
    logic              in_ready;
    logic [PW-1:0]     enq_data;
    logic [PW-1:0]     head_data;

    assign accept = IN_VALID & in_ready;
    assign squash = (shadow_cnt_reg != 2'd0);
    assign live   = accept & ~squash;
    // Evaluated on flags_reg, i.e. the flags before this edge; a flag
    // update from the previous beat is already registered here.
    assign taken  = live & BR_EN & cond_holds(flags_reg, BR_COND);

    assign enq_data = {REG_WE, DEST, ALU_OUT};

    skid_buffer2 #(
        .W (PW)
    ) u_skid (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (live),
        .in_ready  (in_ready),
        .in_data   (enq_data),
        .out_valid (OUT_VALID),
        .out_ready (OUT_READY),
        .out_data  (head_data)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            flags_reg      <= 4'b0000;
            shadow_cnt_reg <= 2'd0;
            br_taken_reg   <= 1'b0;
            br_pc_reg      <= '0;
        end else begin
            br_taken_reg <= taken;
            if (taken)
                br_pc_reg <= BR_TARGET;
            if (live && FLAG_WE)
                flags_reg <= FLAG_OUT;
            // A squashed beat cannot branch, so load and decrement never
            // collide.
            if (taken)
                shadow_cnt_reg <= SHADOW_LOAD;
            else if (accept && squash)
                shadow_cnt_reg <= shadow_cnt_reg - 2'd1;
        end
    end

    assign IN_READY = in_ready;
    assign WB_WE    = head_data[PW-1];
    assign WB_DEST  = head_data[DATA_W +: REG_AW];
    assign WB_DATA  = head_data[DATA_W-1:0];
    assign BR_TAKEN = br_taken_reg;
    assign BR_PC    = br_pc_reg;
    assign FLAGS    = flags_reg;

endmodule

// File: tb/tb_exec_result_stage.sv
module tb_exec_result_stage;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int SHADOW = 2;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              IN_VALID = 1'b0;
    logic              IN_READY;
    logic [DATA_W-1:0] ALU_OUT = '0;
    logic [3:0]        FLAG_OUT = '0;
    logic              FLAG_WE = 1'b0;
    logic              REG_WE = 1'b0;
    logic [REG_AW-1:0] DEST = '0;
    logic              BR_EN = 1'b0;
    logic [2:0]        BR_COND = '0;
    logic [DATA_W-1:0] BR_TARGET = '0;
    logic              OUT_VALID;
    logic              OUT_READY = 1'b1;
    logic [DATA_W-1:0] WB_DATA;
    logic [REG_AW-1:0] WB_DEST;
    logic              WB_WE;
    logic              BR_TAKEN;
    logic [DATA_W-1:0] BR_PC;
    logic [3:0]        FLAGS;

    always #5 CLK = ~CLK;

    exec_result_stage #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .SHADOW (SHADOW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .ALU_OUT   (ALU_OUT),
        .FLAG_OUT  (FLAG_OUT),
        .FLAG_WE   (FLAG_WE),
        .REG_WE    (REG_WE),
        .DEST      (DEST),
        .BR_EN     (BR_EN),
        .BR_COND   (BR_COND),
        .BR_TARGET (BR_TARGET),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .WB_DATA   (WB_DATA),
        .WB_DEST   (WB_DEST),
        .WB_WE     (WB_WE),
        .BR_TAKEN  (BR_TAKEN),
        .BR_PC     (BR_PC),
        .FLAGS     (FLAGS)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  dest;
        logic        we;
    } wb_t;

    int          tests = 0;
    int          fails = 0;
    wb_t         sb_q[$];
    logic [3:0]  m_flags = 4'b0000;
    logic [3:0]  exp_flags = 4'b0000;
    int          m_sh = 0;
    bit          exp_taken = 1'b0;
    logic [15:0] exp_pc = '0;
    bit          chk_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_cond(input logic [3:0] f, input logic [2:0] cc);
        bit s, z, c, v;
        s = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc)
            3'd0: return z;
            3'd1: return s != v;
            3'd2: return z || (s != v);
            3'd3: return !z;
            3'd4: return c;
            3'd5: return s == v;
            3'd6: return !z && (s == v);
            default: return 1'b1;
        endcase
    endfunction

    // Per-cycle checks of flags / branch pulse and scoreboard of writeback.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("flags", 32'(FLAGS), 32'(exp_flags));
            chk("br_taken", 32'(BR_TAKEN), 32'(exp_taken));
            if (exp_taken) chk("br_pc", 32'(BR_PC), 32'(exp_pc));
            if (OUT_VALID) begin
                if (sb_q.size() == 0) begin
                    chk("wb_unexpected", 32'(OUT_VALID), 32'(0));
                end else begin
                    chk("wb_data", 32'(WB_DATA), 32'(sb_q[0].data));
                    chk("wb_dest", 32'(WB_DEST), 32'(sb_q[0].dest));
                    chk("wb_we", 32'(WB_WE), 32'(sb_q[0].we));
                    if (OUT_READY) begin
                        $display("[TB] wb data=%h dest=%0d we=%0b", WB_DATA, WB_DEST, WB_WE);
                        void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        exp_taken = 1'b0;
    endtask

    task automatic idle(input int n);
        IN_VALID = 1'b0;
        repeat (n) step();
    endtask

    task automatic beat(input logic [15:0] d, input logic [2:0] dst, input logic we,
                        input logic fwe, input logic [3:0] fo,
                        input logic br, input logic [2:0] cc, input logic [15:0] tgt);
        bit  got = 1'b0;
        bit  tk = 1'b0;
        bit  sq = 1'b0;
        wb_t e;
        ALU_OUT = d; DEST = dst; REG_WE = we; FLAG_WE = fwe; FLAG_OUT = fo;
        BR_EN = br; BR_COND = cc; BR_TARGET = tgt; IN_VALID = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK);
            if (IN_READY === 1'b1) begin
                got = 1'b1;
                break;
            end
            step();
        end
        if (!got) begin
            chk("accept_timeout", 32'(IN_READY), 32'(1));
            IN_VALID = 1'b0;
            step();
            return;
        end
        if (m_sh != 0) begin
            m_sh--;
            sq = 1'b1;
        end else begin
            tk = br && model_cond(m_flags, cc);
            if (fwe) m_flags = fo;
            e.data = d; e.dest = dst; e.we = we;
            sb_q.push_back(e);
            if (tk) m_sh = SHADOW;
        end
        step();
        IN_VALID = 1'b0;
        exp_taken = tk;
        if (tk) exp_pc = tgt;
        exp_flags = m_flags;
        $display("[TB] beat data=%h dest=%0d squashed=%0b taken=%0b", d, dst, sq, tk);
    endtask

    initial begin
        RST_N = 1'b0;
        OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk_en = 1'b1;
        chk("rst_in_ready", 32'(IN_READY), 32'(0));
        chk("rst_out_valid", 32'(OUT_VALID), 32'(0));
        chk("rst_wb_data", 32'(WB_DATA), 32'(0));
        chk("rst_wb_dest", 32'(WB_DEST), 32'(0));
        chk("rst_wb_we", 32'(WB_WE), 32'(0));
        chk("rst_br_pc", 32'(BR_PC), 32'(0));
        RST_N = 1'b1;
        step();
        chk("in_ready_after_rst", 32'(IN_READY), 32'(1));

        // Single beat, one-cycle latency.
        beat(16'h1234, 3'd5, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
        chk("t1_out_valid", 32'(OUT_VALID), 32'(1));
        chk("t1_wb_data", 32'(WB_DATA), 32'h1234);
        chk("t1_wb_dest", 32'(WB_DEST), 32'(5));
        chk("t1_wb_we", 32'(WB_WE), 32'(1));
        chk("t1_in_ready", 32'(IN_READY), 32'(1));
        idle(2);

        // Back-pressure fills both entries, then drains in order.
        OUT_READY = 1'b0;
        beat(16'hA0A0, 3'd1, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
        beat(16'hB0B0, 3'd2, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
        chk("t2_full_in_ready", 32'(IN_READY), 32'(0));
        idle(2);
        chk("t2_hold_in_ready", 32'(IN_READY), 32'(0));
        chk("t2_hold_data", 32'(WB_DATA), 32'hA0A0);
        OUT_READY = 1'b1;
        beat(16'hC0C0, 3'd3, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
        idle(3);
        chk("t2_drained", 32'(sb_q.size()), 32'(0));
        chk("t2_out_valid", 32'(OUT_VALID), 32'(0));

        // CMP then branch back-to-back, followed by the squashed shadow.
        beat(16'h0011, 3'd4, 1'b1, 1'b1, 4'b0100, 1'b0, 3'd0, 16'h0);
        beat(16'h0022, 3'd6, 1'b0, 1'b0, 4'h0, 1'b1, 3'b000, 16'h0040);
        chk("t3_br_taken", 32'(BR_TAKEN), 32'(1));
        chk("t3_br_pc", 32'(BR_PC), 32'h0040);
        chk("t3_flags", 32'(FLAGS), 32'b0100);
        beat(16'h0033, 3'd7, 1'b1, 1'b1, 4'b1000, 1'b0, 3'd0, 16'h0);
        chk("t4_pulse_gone", 32'(BR_TAKEN), 32'(0));
        beat(16'h0044, 3'd7, 1'b1, 1'b1, 4'b1000, 1'b0, 3'd0, 16'h0);
        beat(16'h0055, 3'd1, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
        idle(3);
        chk("t4_flags_kept", 32'(FLAGS), 32'b0100);
        chk("t4_drained", 32'(sb_q.size()), 32'(0));

        // LT with S=1,V=1 is not taken and squashes nothing.
        beat(16'h0066, 3'd2, 1'b1, 1'b1, 4'b1001, 1'b0, 3'd0, 16'h0);
        beat(16'h0077, 3'd3, 1'b0, 1'b0, 4'h0, 1'b1, 3'b001, 16'h0080);
        chk("t5_not_taken", 32'(BR_TAKEN), 32'(0));
        beat(16'h0088, 3'd4, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
        idle(3);
        chk("t5_drained", 32'(sb_q.size()), 32'(0));

        // Every condition code against C-only flags.
        for (int cc = 0; cc < 8; cc++) begin
            beat(16'h1000 + 16'(cc), 3'd1, 1'b1, 1'b1, 4'b0010, 1'b0, 3'd0, 16'h0);
            beat(16'h2000 + 16'(cc), 3'd2, 1'b1, 1'b0, 4'h0, 1'b1, 3'(cc), 16'h0100 + 16'(cc));
            for (int k = 0; k < 3; k++)
                beat(16'h3000 + 16'(cc * 4 + k), 3'(k), 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
        end
        idle(3);
        chk("t6_drained", 32'(sb_q.size()), 32'(0));

        // Reset while full, shadow armed and branch pulse pending.
        OUT_READY = 1'b0;
        beat(16'h0101, 3'd2, 1'b1, 1'b1, 4'b0110, 1'b0, 3'd0, 16'h0);
        beat(16'h0202, 3'd3, 1'b1, 1'b0, 4'h0, 1'b1, 3'b111, 16'h00F0);
        chk("t7_full", 32'(IN_READY), 32'(0));
        RST_N = 1'b0;
        step();
        m_flags = 4'b0000;
        exp_flags = 4'b0000;
        m_sh = 0;
        sb_q.delete();
        chk("t7_rst_in_ready", 32'(IN_READY), 32'(0));
        chk("t7_rst_out_valid", 32'(OUT_VALID), 32'(0));
        chk("t7_rst_br_taken", 32'(BR_TAKEN), 32'(0));
        chk("t7_rst_flags", 32'(FLAGS), 32'(0));
        RST_N = 1'b1;
        OUT_READY = 1'b1;
        step();
        chk("t7_in_ready", 32'(IN_READY), 32'(1));
        chk("t7_out_valid", 32'(OUT_VALID), 32'(0));
        beat(16'h0303, 3'd4, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
        chk("t7_not_squashed", 32'(OUT_VALID), 32'(1));
        chk("t7_wb_data", 32'(WB_DATA), 32'h0303);
        idle(3);
        chk("t7_drained", 32'(sb_q.size()), 32'(0));

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
